// File: rtl/riscv_pkg.sv
// Shared RV32I constants: ALU operation codes, R-type opcode/funct fields
// and the sequencer FSM state encoding.
package riscv_pkg;

   localparam logic [6:0] ALU_NOP  = 7'd0;
   localparam logic [6:0] ALU_ADD  = 7'd1;
   localparam logic [6:0] ALU_SUB  = 7'd2;
   localparam logic [6:0] ALU_SLL  = 7'd3;
   localparam logic [6:0] ALU_SLT  = 7'd4;
   localparam logic [6:0] ALU_SLTU = 7'd5;
   localparam logic [6:0] ALU_XOR  = 7'd6;
   localparam logic [6:0] ALU_SRL  = 7'd7;
   localparam logic [6:0] ALU_SRA  = 7'd8;
   localparam logic [6:0] ALU_OR   = 7'd9;
   localparam logic [6:0] ALU_AND  = 7'd10;

   localparam logic [6:0] OPCODE_OP = 7'b0110011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_DECODE = 2'd1;
   localparam state_t ST_EXEC   = 2'd2;
   localparam state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decoder: instruction word -> ALU operation and an
// illegal flag. Illegal words always map to ALU_NOP.
module rtype_decoder
   import riscv_pkg::*;
(
   input  logic [31:0] instr,
   output logic [6:0]  operation,
   output logic        illegal
);

   logic [6:0] funct7;
   logic [2:0] funct3;

   assign funct7 = instr[31:25];
   assign funct3 = instr[14:12];

   always_comb begin
      operation = ALU_NOP;
      illegal   = 1'b1;
      if (instr[6:0] == OPCODE_OP) begin
         illegal = 1'b0;
         case ({funct7, funct3})
            {F7_BASE, F3_ADD_SUB}: operation = ALU_ADD;
            {F7_ALT,  F3_ADD_SUB}: operation = ALU_SUB;
            {F7_BASE, F3_SLL}:     operation = ALU_SLL;
            {F7_BASE, F3_SLT}:     operation = ALU_SLT;
            {F7_BASE, F3_SLTU}:    operation = ALU_SLTU;
            {F7_BASE, F3_XOR}:     operation = ALU_XOR;
            {F7_BASE, F3_SRL_SRA}: operation = ALU_SRL;
            {F7_ALT,  F3_SRL_SRA}: operation = ALU_SRA;
            {F7_BASE, F3_OR}:      operation = ALU_OR;
            {F7_BASE, F3_AND}:     operation = ALU_AND;
            default: begin
               operation = ALU_NOP;
               illegal   = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle R-type sequencer: one instruction in flight, IDLE->DECODE->EXEC->RESP,
// driving register-file/ALU controls and returning a zero/illegal response.
module datapath_sequencer
   import riscv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   input  logic [31:0]      instr,
   output logic             instr_ready,
   input  logic             zero_flag,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rw,
   output logic [6:0]       operation,
   output logic             write,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_zero,
   output logic             resp_illegal,
   output logic [CNT_W-1:0] retired_count,
   output state_t           dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; valid never waits on ready, and ready never looks at valid.
   state_t     state;
   logic [6:0] op_q;
   logic       illegal_q;
   logic [6:0] dec_op;
   logic       dec_illegal;

   rtype_decoder u_decoder (
      .instr     (instr),
      .operation (dec_op),
      .illegal   (dec_illegal)
   );

   assign instr_ready = (state == ST_IDLE);
   assign resp_valid  = (state == ST_RESP);
   assign write       = (state == ST_EXEC) && (rw != 5'd0);
   assign operation   = (state == ST_IDLE) ? ALU_NOP : op_q;
   assign dbg_state   = state;

   // Fields are captured at the accept edge so they are already valid in DECODE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         rs1           <= 5'd0;
         rs2           <= 5'd0;
         rw            <= 5'd0;
         op_q          <= ALU_NOP;
         illegal_q     <= 1'b0;
         resp_zero     <= 1'b0;
         resp_illegal  <= 1'b0;
         retired_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (instr_valid) begin
                  rs1       <= instr[19:15];
                  rs2       <= instr[24:20];
                  rw        <= instr[11:7];
                  op_q      <= dec_op;
                  illegal_q <= dec_illegal;
                  state     <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (illegal_q) begin
                  resp_zero    <= 1'b0;
                  resp_illegal <= 1'b1;
                  state        <= ST_RESP;
               end else begin
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               resp_zero     <= zero_flag;
               resp_illegal  <= 1'b0;
               retired_count <= retired_count + 1'b1;
               state         <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed R-type cases, random
// instruction stream against a table-driven reference, reset-in-EXEC and wrap.
module tb_datapath_sequencer;
   import riscv_pkg::*;

   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             instr_valid;
   logic [31:0]      instr;
   logic             instr_ready;
   logic             zero_flag;
   logic [4:0]       rs1, rs2, rw;
   logic [6:0]       operation;
   logic             write;
   logic             resp_valid;
   logic             resp_ready;
   logic             resp_zero;
   logic             resp_illegal;
   logic [CNT_W-1:0] retired_count;
   state_t           dbg_state;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   logic [1:0] exp_q[$];

   datapath_sequencer #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_ready   (instr_ready),
      .zero_flag     (zero_flag),
      .rs1           (rs1),
      .rs2           (rs2),
      .rw            (rw),
      .operation     (operation),
      .write         (write),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_zero     (resp_zero),
      .resp_illegal  (resp_illegal),
      .retired_count (retired_count),
      .dbg_state     (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference decode: the legal R-type set as a plain lookup table.
   logic [6:0] ref_f7 [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
   logic [2:0] ref_f3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
   logic [6:0] ref_op [10] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                               ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};

   task automatic ref_decode(input logic [31:0] w, output logic legal, output logic [6:0] op);
      legal = 1'b0;
      op    = ALU_NOP;
      if (w[6:0] == 7'b0110011)
         for (int i = 0; i < 10; i++)
            if (w[31:25] == ref_f7[i] && w[14:12] == ref_f3[i]) begin
               legal = 1'b1;
               op    = ref_op[i];
            end
   endtask

   function automatic logic [31:0] enc(input int k, input logic [4:0] rd,
                                       input logic [4:0] a, input logic [4:0] b);
      return {ref_f7[k], b, a, ref_f3[k], rd, 7'b0110011};
   endfunction

   // Drive one instruction through accept, execute and response; resp is held
   // off for hold cycles while a competing instruction is offered.
   task automatic run_instr(input logic [31:0] w, input logic z, input int hold);
      logic legal;
      logic [6:0] op;
      logic [1:0] exp_resp;
      int n, wr;
      ref_decode(w, legal, op);
      exp_q.push_back({~legal, legal & z});
      check("idle_ready", instr_ready, 1);
      check("idle_op", operation, ALU_NOP);
      instr_valid = 1'b1;
      instr       = w;
      zero_flag   = z;
      step();
      instr_valid = 1'b0;
      instr       = $urandom;
      check("dec_rs1", rs1, w[19:15]);
      check("dec_rs2", rs2, w[24:20]);
      check("dec_rw", rw, w[11:7]);
      check("dec_op", operation, op);
      check("dec_write", write, 0);
      check("dec_ready", instr_ready, 0);
      n = 0;
      wr = 0;
      while (n < 8) begin
         step();
         n++;
         if (resp_valid) break;
         if (write) wr++;
         check("exec_rs1", rs1, w[19:15]);
         check("exec_op", operation, op);
      end
      check("resp_latency", n, legal ? 2 : 1);
      check("write_cycles", wr, (legal && w[11:7] != 5'd0) ? 1 : 0);
      if (!resp_valid) return;
      if (legal) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      exp_resp = exp_q.pop_front();
      check("resp_illegal", resp_illegal, exp_resp[1]);
      check("resp_zero", resp_zero, exp_resp[0]);
      check("resp_write", write, 0);
      for (int i = 0; i < hold; i++) begin
         instr_valid = 1'b1;
         instr       = enc(0, 5'd7, 5'd7, 5'd7);
         step();
         check("hold_valid", resp_valid, 1);
         check("hold_illegal", resp_illegal, exp_resp[1]);
         check("hold_zero", resp_zero, exp_resp[0]);
         check("hold_ready", instr_ready, 0);
      end
      instr_valid = 1'b0;
      resp_ready  = 1'b1;
      step();
      resp_ready = 1'b0;
      check("post_valid", resp_valid, 0);
      check("post_ready", instr_ready, 1);
      check("post_op", operation, ALU_NOP);
      check("post_rw_hold", rw, w[11:7]);
      check("retired", retired_count, exp_cnt);
   endtask

   initial begin
      logic [31:0] w;
      int k;
      reset       = 1'b1;
      instr_valid = 1'b0;
      instr       = '0;
      zero_flag   = 1'b0;
      resp_ready  = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      step();
      check("rst_ready", instr_ready, 1);
      check("rst_write", write, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_zero", resp_zero, 0);
      check("rst_resp_illegal", resp_illegal, 0);
      check("rst_rs", {rs1, rs2, rw}, 0);
      check("rst_op", operation, ALU_NOP);
      check("rst_count", retired_count, 0);

      // directed cases
      check("add_word", enc(0, 5'd3, 5'd1, 5'd2), 32'h002081B3);
      run_instr(32'h002081B3, 1'b0, 0);
      run_instr(enc(1, 5'd5, 5'd4, 5'd4), 1'b1, 0);
      run_instr(32'h00000013, 1'b1, 0);
      run_instr(enc(0, 5'd0, 5'd1, 5'd2), 1'b0, 0);
      run_instr(enc(9, 5'd9, 5'd10, 5'd11), 1'b1, 5);

      // reset during EXEC
      instr_valid = 1'b1;
      instr       = enc(0, 5'd3, 5'd1, 5'd2);
      step();
      instr_valid = 1'b0;
      step();
      check("exec_write", write, 1);
      #2 reset = 1'b1;
      #1;
      check("arst_write", write, 0);
      check("arst_resp_valid", resp_valid, 0);
      check("arst_count", retired_count, 0);
      exp_cnt = 0;
      step();
      reset = 1'b0;
      step();
      check("arst_ready", instr_ready, 1);
      run_instr(32'h002081B3, 1'b0, 1);

      // random stream, long enough to wrap the 4-bit counter
      for (int t = 0; t < 40; t++) begin
         k = $urandom_range(0, 9);
         case ($urandom_range(0, 3))
            0: w = $urandom;
            1: w = {7'($urandom_range(0, 127)), 25'($urandom)} | 32'h33;
            default: w = enc(k, 5'($urandom), 5'($urandom), 5'($urandom));
         endcase
         run_instr(w, 1'($urandom), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
